// File: rtl/led_pwm_multi.sv
// led_pwm_multi: N-channel LED dimmer with debounced up/down buttons, a global breathing mode
// and a shared PWM counter whose per-channel duty is latched at each period start.
module led_pwm_multi #(
    parameter int NCH        = 4,
    parameter int DW         = 8,
    parameter int STEP       = 32,
    parameter int DEB_CYCLES = 1000000,
    parameter int PWM_DIV    = 4,
    parameter int BREATH_DIV = 100000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] btn_up,
    input  logic [NCH-1:0] btn_dn,
    input  logic           btn_mode,
    output logic [NCH-1:0] led,
    output logic           mode_breath
);
    localparam int NB = 2 * NCH + 1;
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam int PW = $clog2(PWM_DIV + 1);
    localparam int BW = $clog2(BREATH_DIV + 1);

    typedef enum logic {MANUAL, BREATH} state_t;

    logic [1:0]              rst_sync;
    logic                    arst_n;
    logic [NB-1:0]           raw, s1, s2, press;
    logic [NCH-1:0][DW-1:0]  eff, shadow, sh_n;
    logic [PW-1:0]           pre;
    logic [DW-1:0]           cnt, ramp, ramp_n;
    logic [BW-1:0]           bdiv;
    logic                    dir, load;
    state_t                  state;

    // reset asserts immediately but releases on a clock edge
    always_ff @(posedge clk or negedge rst)
        if (!rst) rst_sync <= '0;
        else      rst_sync <= {rst_sync[0], 1'b1};
    assign arst_n = rst_sync[1];

    assign raw = {btn_mode, btn_dn, btn_up};

    always_ff @(posedge clk or negedge arst_n)
        if (!arst_n) {s2, s1} <= '0;
        else         {s2, s1} <= {s1, raw};

    for (genvar g = 0; g < NB; g++) begin : g_deb
        logic [CW-1:0] dcnt;
        logic          stable, pulse, done;
        assign done     = (s2[g] != stable) && (dcnt == CW'(DEB_CYCLES - 1));
        assign press[g] = pulse;
        always_ff @(posedge clk or negedge arst_n)
            if (!arst_n) begin
                dcnt   <= '0;
                stable <= 1'b0;
                pulse  <= 1'b0;
            end else begin
                dcnt   <= (s2[g] != stable && !done) ? dcnt + 1'b1 : '0;
                stable <= done ? s2[g] : stable;
                pulse  <= done & s2[g];
            end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [DW-1:0]   duty;
        logic [DW:0]     inc, dec;
        logic [2*DW-1:0] prod;
        assign inc    = {1'b0, duty} + (DW+1)'(STEP);
        assign dec    = {1'b0, duty} - (DW+1)'(STEP);
        assign prod   = {{DW{1'b0}}, duty} * {{DW{1'b0}}, ramp};
        assign eff[g] = (state == BREATH) ? DW'(prod >> DW) : duty;
        always_ff @(posedge clk or negedge arst_n)
            if (!arst_n) duty <= '0;
            else duty <= (press[g] && !press[NCH+g]) ? (inc[DW] ? '1 : inc[DW-1:0]) :
                         (press[NCH+g] && !press[g]) ? (dec[DW] ? '0 : dec[DW-1:0]) : duty;
    end

    assign ramp_n = dir ? ramp + 1'b1 : ramp - 1'b1;

    always_ff @(posedge clk or negedge arst_n)
        if (!arst_n) begin
            state       <= MANUAL;
            mode_breath <= 1'b0;
            ramp        <= '0;
            dir         <= 1'b1;
            bdiv        <= '0;
        end else if (press[2*NCH]) begin
            state       <= (state == MANUAL) ? BREATH : MANUAL;
            mode_breath <= (state == MANUAL);
            if (state == MANUAL) begin
                ramp <= '0;
                dir  <= 1'b1;
                bdiv <= '0;
            end
        end else if (state == BREATH) begin
            bdiv <= (bdiv == BW'(BREATH_DIV - 1)) ? '0 : bdiv + 1'b1;
            if (bdiv == BW'(BREATH_DIV - 1)) begin
                ramp <= ramp_n;
                if (&ramp_n)            dir <= 1'b0;
                else if (ramp_n == '0)  dir <= 1'b1;
            end
        end

    // new duty is applied on the period-start cycle itself so the whole period uses it
    assign load = (cnt == '0) && (pre == '0);
    assign sh_n = load ? eff : shadow;

    always_ff @(posedge clk or negedge arst_n)
        if (!arst_n) begin
            pre    <= '0;
            cnt    <= '0;
            shadow <= '0;
            led    <= '0;
        end else begin
            pre    <= (pre == PW'(PWM_DIV - 1)) ? '0 : pre + 1'b1;
            cnt    <= (pre == PW'(PWM_DIV - 1)) ? cnt + 1'b1 : cnt;
            shadow <= sh_n;
            for (int i = 0; i < NCH; i++)
                led[i] <= (&sh_n[i]) | (cnt < sh_n[i]);
        end
endmodule

// File: tb/tb_led_pwm_multi.sv
// tb_led_pwm_multi: scoreboard bench; expected PWM high-times are queued as buttons are driven
// and compared against high-times measured on the led outputs.
module tb_led_pwm_multi;
    localparam int NCH = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [NCH-1:0] btn_up = '0;
    logic [NCH-1:0] btn_dn = '0;
    logic           btn_mode = 1'b0;
    logic [NCH-1:0] led;
    logic           mode_breath;

    int errors = 0;
    int checks = 0;
    int exp_q[$];
    int model[NCH] = '{0, 0};

    led_pwm_multi #(
        .NCH(NCH), .DW(8), .STEP(32), .DEB_CYCLES(4), .PWM_DIV(1), .BREATH_DIV(2)
    ) dut (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_dn(btn_dn), .btn_mode(btn_mode),
        .led(led), .mode_breath(mode_breath)
    );

    always #5 clk = ~clk;

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int ch, input bit up, input bit dn);
        @(negedge clk);
        btn_up[ch] = up;
        btn_dn[ch] = dn;
        cycles(10);
        btn_up[ch] = 1'b0;
        btn_dn[ch] = 1'b0;
        cycles(10);
        if (up && !dn)      model[ch] = (model[ch] + 32 > 255) ? 255 : model[ch] + 32;
        else if (dn && !up) model[ch] = (model[ch] - 32 < 0) ? 0 : model[ch] - 32;
    endtask

    task automatic press_mode();
        @(negedge clk);
        btn_mode = 1'b1;
        cycles(10);
        btn_mode = 1'b0;
        cycles(10);
    endtask

    // duty 255 is constantly on, so a full 256-cycle period reads 256 high samples
    task automatic expect_duty(input int ch);
        exp_q.push_back(model[ch] == 255 ? 256 : model[ch]);
    endtask

    task automatic measure(input int ch, output int n);
        cycles(300);
        n = 0;
        repeat (256) begin
            @(negedge clk);
            n += int'(led[ch]);
        end
    endtask

    task automatic check_duty(input int ch, input string name);
        int got, want;
        measure(ch, got);
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: led[%0d] high %0d of 256, expected %0d", name, ch, got, want);
        end
    endtask

    task automatic test_reset();
        cycles(3);
        checks++;
        if (led !== 2'b00) begin errors++; $display("FAIL reset_led_in: got %b want 00", led); end
        checks++;
        if (mode_breath !== 1'b0) begin errors++; $display("FAIL reset_mode_in: got %b want 0", mode_breath); end
        rst = 1'b1;
        cycles(5);
        checks++;
        if (led !== 2'b00) begin errors++; $display("FAIL reset_led_out: got %b want 00", led); end
        checks++;
        if (mode_breath !== 1'b0) begin errors++; $display("FAIL reset_mode_out: got %b want 0", mode_breath); end
    endtask

    task automatic test_single_press();
        press(0, 1'b1, 1'b0);
        expect_duty(0);
        expect_duty(1);
        check_duty(0, "single_up");
        check_duty(1, "single_other_ch");
    endtask

    task automatic test_saturate();
        repeat (9) press(0, 1'b1, 1'b0);
        expect_duty(0);
        check_duty(0, "sat_high");
        repeat (9) press(0, 1'b0, 1'b1);
        expect_duty(0);
        check_duty(0, "sat_low");
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            btn_up[1] = ~btn_up[1];
            cycles(1);
        end
        btn_up[1] = 1'b0;
        cycles(10);
        expect_duty(1);
        expect_duty(0);
        check_duty(1, "bounce_ch1");
        check_duty(0, "bounce_ch0");
    endtask

    task automatic test_simultaneous();
        press(0, 1'b1, 1'b0);
        press(0, 1'b1, 1'b0);
        expect_duty(0);
        check_duty(0, "pre_simul");
        press(0, 1'b1, 1'b1);
        expect_duty(0);
        check_duty(0, "simul_no_change");
    endtask

    task automatic test_breath();
        int runs[$];
        int cur, mx, mn;
        bit rose, fell;
        repeat (6) press(0, 1'b1, 1'b0);
        expect_duty(0);
        check_duty(0, "breath_pre_full");
        press_mode();
        checks++;
        if (mode_breath !== 1'b1) begin errors++; $display("FAIL breath_enter: got %b want 1", mode_breath); end
        cur = 0;
        repeat (8 * 256) begin
            @(negedge clk);
            if (led[0]) cur++;
            else if (cur > 0) begin
                runs.push_back(cur);
                cur = 0;
            end
        end
        if (runs.size() > 0) void'(runs.pop_front());
        mx = 0; mn = 1000; rose = 0; fell = 0;
        foreach (runs[i]) begin
            if (runs[i] > mx) mx = runs[i];
            if (runs[i] < mn) mn = runs[i];
            if (i > 0 && runs[i] > runs[i-1]) rose = 1;
            if (i > 0 && runs[i] < runs[i-1]) fell = 1;
        end
        checks++;
        if (runs.size() < 5) begin errors++; $display("FAIL breath_periods: got %0d runs want >=5", runs.size()); end
        checks++;
        if (mx <= 150) begin errors++; $display("FAIL breath_peak: got %0d want >150", mx); end
        checks++;
        if (mn >= 110) begin errors++; $display("FAIL breath_trough: got %0d want <110", mn); end
        checks++;
        if (!(rose && fell)) begin errors++; $display("FAIL breath_shape: rose=%0d fell=%0d want 1 1", rose, fell); end
        press_mode();
        checks++;
        if (mode_breath !== 1'b0) begin errors++; $display("FAIL breath_exit: got %b want 0", mode_breath); end
        expect_duty(0);
        check_duty(0, "manual_restore");
    endtask

    task automatic test_reset_mid();
        int t;
        repeat (8) press(0, 1'b0, 1'b1);
        repeat (3) press(0, 1'b1, 1'b0);
        press_mode();
        t = 0;
        while (led[0] !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (led[0] !== 1'b1) begin errors++; $display("FAIL rstmid_wait_led: got %b want 1", led[0]); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (led !== 2'b00) begin errors++; $display("FAIL rstmid_led: got %b want 00", led); end
        checks++;
        if (mode_breath !== 1'b0) begin errors++; $display("FAIL rstmid_mode: got %b want 0", mode_breath); end
        @(negedge clk);
        rst = 1'b1;
        model[0] = 0;
        model[1] = 0;
        expect_duty(0);
        check_duty(0, "rstmid_duty");
        checks++;
        if (mode_breath !== 1'b0) begin errors++; $display("FAIL rstmid_mode_after: got %b want 0", mode_breath); end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_saturate();
        test_bounce();
        test_simultaneous();
        test_breath();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
